// File: rtl/outbuf_pkg.sv
// Shared types and sizing helpers for the output elastic buffer.
// The word width is set by NUM below (sign bit included: word is NUM+1 bits wide).
package outbuf_pkg;

  localparam int unsigned NUM    = 15;
  localparam int unsigned STAT_W = 32;

  typedef logic signed [NUM:0] word_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/outbuf_fifo_if.sv
// Core-side and downstream-side valid/stop handshake of the output buffer.
// master is the buffer, slave is the surrounding core/consumer pair.
interface outbuf_fifo_if;
  import outbuf_pkg::*;

  word_t cdata;
  logic  cvalid;
  logic  cstop;
  word_t odata;
  logic  ovalid;
  logic  ostop;

  modport master (input cdata, cvalid, ostop, output cstop, odata, ovalid);
  modport slave  (output cdata, cvalid, ostop, input cstop, odata, ovalid);

endinterface

// File: rtl/outbuf_mem.sv
// DEPTH-entry word storage: one synchronous write port, combinational read by address.
module outbuf_mem
  import outbuf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-1:0]   waddr,
  input  word_t                     wdata,
  input  logic [ptr_w(DEPTH)-1:0]   raddr,
  output word_t                     rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/outbuf_fifo.sv
// Output-side elastic buffer with a registered head stage and registered cstop.
// Optional OUTBUF_STATS_EN adds saturating nxfer/nstall/nblock event counters.
module outbuf_fifo
  import outbuf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AFULL = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  outbuf_fifo_if.master            bus,
  output logic [cnt_w(DEPTH)-1:0]  level,
  output logic                     afull
`ifdef OUTBUF_STATS_EN
  ,
  output logic [STAT_W-1:0]        nxfer,
  output logic [STAT_W-1:0]        nstall,
  output logic [STAT_W-1:0]        nblock
`endif
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [PTR_W-1:0] wp, rp, rp_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             wr, rd;
  word_t            mem_rdata;

  assign wr   = bus.cvalid && !bus.cstop && !flush;
  assign rd   = bus.ovalid && !bus.ostop;
  assign rp_n = rd ? rp + PTR_W'(1) : rp;

  always_comb begin
    cnt_n = cnt;
    case ({wr, rd})
      2'b10:   cnt_n = cnt + CNT_W'(1);
      2'b01:   cnt_n = cnt - CNT_W'(1);
      default: cnt_n = cnt;
    endcase
  end

  outbuf_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr),
    .waddr (wp),
    .wdata (bus.cdata),
    .raddr (rp_n),
    .rdata (mem_rdata)
  );

  // Head reload bypasses the array when the incoming word becomes the new head.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      bus.ovalid <= 1'b0;
      bus.cstop <= 1'b0;
      afull     <= 1'b0;
      bus.odata <= '0;
    end else begin
      if (wr) wp <= wp + PTR_W'(1);
      rp         <= rp_n;
      cnt        <= cnt_n;
      bus.ovalid <= (cnt_n != '0);
      bus.cstop  <= (cnt_n == CNT_W'(DEPTH));
      afull      <= (cnt_n >= CNT_W'(AFULL));
      if (rd || (wr && cnt == '0))
        bus.odata <= (wr && wp == rp_n) ? bus.cdata : mem_rdata;
    end
  end

  assign level = cnt;

`ifdef OUTBUF_STATS_EN
  // Event counters survive flush and stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      nxfer  <= '0;
      nstall <= '0;
      nblock <= '0;
    end else begin
      if (rd && nxfer != '1)                      nxfer  <= nxfer + STAT_W'(1);
      if (bus.ovalid && bus.ostop && nstall != '1) nstall <= nstall + STAT_W'(1);
      if (bus.cvalid && bus.cstop && nblock != '1) nblock <= nblock + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_outbuf_fifo.sv
// Randomised and directed bench for outbuf_fifo against a queue-based reference model.
module tb_outbuf_fifo;
  import outbuf_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AFULL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [2:0] level;
  logic       afull;
`ifdef OUTBUF_STATS_EN
  logic [31:0] nxfer, nstall, nblock;
`endif

  outbuf_fifo_if bus ();

  outbuf_fifo #(.DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .level (level),
    .afull (afull)
`ifdef OUTBUF_STATS_EN
    ,
    .nxfer  (nxfer),
    .nstall (nstall),
    .nblock (nblock)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of buffered words plus event tallies.
  word_t       q[$];
  bit          last_acc;
  int unsigned m_xfer, m_stall, m_block;

  function automatic logic [5:0] exp_flags();
    return {q.size() != 0, q.size() == DEPTH, q.size() >= AFULL, 3'(q.size())};
  endfunction

  function automatic logic [5:0] act_flags();
    return {bus.ovalid, bus.cstop, afull, level};
  endfunction

  task automatic drive(input logic v, input word_t d, input logic s, input logic f);
    bus.cvalid = v;
    bus.cdata  = d;
    bus.ostop  = s;
    flush      = f;
  endtask

  // Advance model by one clock using the inputs currently applied, then step the DUT.
  task automatic tick();
    bit acc, rdm;
    if (rst) begin
      q.delete();
      m_xfer = 0; m_stall = 0; m_block = 0;
      last_acc = 0;
    end else begin
      acc = bus.cvalid && (q.size() < DEPTH) && !flush;
      rdm = (q.size() != 0) && !bus.ostop;
      if (rdm) m_xfer++;
      if (q.size() != 0 && bus.ostop) m_stall++;
      if (bus.cvalid && q.size() == DEPTH) m_block++;
      if (rdm) void'(q.pop_front());
      if (flush) q.delete();
      else if (acc) q.push_back(bus.cdata);
      last_acc = acc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, '0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 16'sd7, 0, 0);
    tick(); tick();
    rst = 1'b0;
    drive(0, '0, 0, 0);
    tests++;
    if (act_flags() !== 6'b0) begin
      fails++; $display("FAIL reset_flags got %b want %b", act_flags(), 6'b0);
    end
    tests++;
    if (bus.odata !== '0) begin
      fails++; $display("FAIL reset_odata got %0d want 0", bus.odata);
    end
`ifdef OUTBUF_STATS_EN
    tests++;
    if ({nxfer, nstall, nblock} !== 96'b0) begin
      fails++; $display("FAIL reset_stats got %0d/%0d/%0d want 0/0/0", nxfer, nstall, nblock);
    end
`endif
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1, word_t'(10 + i), 0, 0);
      else       drive(0, '0, 0, 0);
      tick();
      tests++;
      if (act_flags() !== exp_flags() || level > 3'd1 || bus.cstop !== 1'b0) begin
        fails++; $display("FAIL stream_flags[%0d] got %b want %b", i, act_flags(), exp_flags());
      end
      if (i < 3) begin
        tests++;
        if (bus.odata !== word_t'(10 + i) || bus.ovalid !== 1'b1) begin
          fails++; $display("FAIL stream_data[%0d] got %0d want %0d", i, bus.odata, 10 + i);
        end
      end
    end
  endtask

  task automatic test_fill();
    int k = 1;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(1, word_t'(k), 1, 0);
      tick();
      if (last_acc) k++;
      tests++;
      if (act_flags() !== exp_flags()) begin
        fails++; $display("FAIL fill_flags[%0d] got %b want %b", c, act_flags(), exp_flags());
      end
    end
    tests++;
    if (level !== 3'd4 || bus.cstop !== 1'b1 || afull !== 1'b1 || bus.odata !== 16'sd1) begin
      fails++; $display("FAIL fill_final got lvl=%0d cstop=%b afull=%b odata=%0d want 4 1 1 1",
                        level, bus.cstop, afull, bus.odata);
    end
`ifdef OUTBUF_STATS_EN
    tests++;
    if (nxfer !== m_xfer || nstall !== m_stall || nblock !== m_block) begin
      fails++; $display("FAIL fill_stats got %0d/%0d/%0d want %0d/%0d/%0d",
                        nxfer, nstall, nblock, m_xfer, m_stall, m_block);
    end
`endif
  endtask

  task automatic test_release();
    drive(1, 16'sd5, 0, 0);
    tick();
    tests++;
    if (level !== 3'd3 || bus.odata !== 16'sd2 || act_flags() !== exp_flags()) begin
      fails++; $display("FAIL release_read got lvl=%0d odata=%0d want 3 2", level, bus.odata);
    end
    drive(1, 16'sd5, 1, 0);
    tick();
    tests++;
    if (level !== 3'd4 || bus.cstop !== 1'b1 || act_flags() !== exp_flags()) begin
      fails++; $display("FAIL release_accept got lvl=%0d cstop=%b want 4 1", level, bus.cstop);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (bus.odata !== word_t'(2 + i) || bus.ovalid !== 1'b1) begin
        fails++; $display("FAIL release_order[%0d] got %0d want %0d", i, bus.odata, 2 + i);
      end
      drive(0, '0, 0, 0);
      tick();
    end
    tests++;
    if (act_flags() !== 6'b0) begin
      fails++; $display("FAIL release_empty got %b want %b", act_flags(), 6'b0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 16'sd100, 1, 0); tick();
    drive(1, 16'sd101, 1, 0); tick();
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (bus.odata !== word_t'((i < 2) ? 100 + i : 18 + i)) begin
        fails++; $display("FAIL b2b_order[%0d] got %0d want %0d", i, bus.odata, (i < 2) ? 100 + i : 18 + i);
      end
      drive(1, word_t'(20 + i), 0, 0);
      tick();
      tests++;
      if (level !== 3'd2 || act_flags() !== exp_flags()) begin
        fails++; $display("FAIL b2b_level[%0d] got %0d want 2", i, level);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, word_t'(50 + i), 1, 0);
      tick();
    end
    drive(1, 16'sd77, 1, 1);
    tick();
    tests++;
    if (act_flags() !== 6'b0 || act_flags() !== exp_flags()) begin
      fails++; $display("FAIL flush_clear got %b want %b", act_flags(), 6'b0);
    end
    drive(1, 16'sd99, 0, 0);
    tick();
    tests++;
    if (bus.ovalid !== 1'b1 || bus.odata !== 16'sd99 || level !== 3'd1) begin
      fails++; $display("FAIL flush_next got v=%b odata=%0d lvl=%0d want 1 99 1", bus.ovalid, bus.odata, level);
    end
    drive(0, '0, 0, 0);
    tick();
    tests++;
    if (bus.ovalid !== 1'b0 || level !== 3'd0) begin
      fails++; $display("FAIL flush_alone got v=%b lvl=%0d want 0 0", bus.ovalid, level);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    drive(1, 16'sd60, 1, 0); tick();
    drive(1, 16'sd61, 1, 0); tick();
    rst = 1'b1;
    drive(1, 16'sd62, 1, 0);
    tick();
    rst = 1'b0;
    tests++;
    if (act_flags() !== 6'b0 || bus.odata !== '0) begin
      fails++; $display("FAIL midrst_state got %b odata=%0d want %b 0", act_flags(), bus.odata, 6'b0);
    end
`ifdef OUTBUF_STATS_EN
    tests++;
    if ({nxfer, nstall, nblock} !== 96'b0) begin
      fails++; $display("FAIL midrst_stats got %0d/%0d/%0d want 0/0/0", nxfer, nstall, nblock);
    end
`endif
    drive(1, 16'sd42, 0, 0);
    tick();
    tests++;
    if (bus.odata !== 16'sd42 || level !== 3'd1) begin
      fails++; $display("FAIL midrst_first got odata=%0d lvl=%0d want 42 1", bus.odata, level);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(logic'($urandom_range(0, 1)), word_t'($urandom), logic'($urandom_range(0, 2) == 0),
            logic'($urandom_range(0, 30) == 0));
      tick();
      tests++;
      if (act_flags() !== exp_flags() || (q.size() != 0 && bus.odata !== q[0])) begin
        fails++; $display("FAIL random[%0d] got %b/%0d want %b/%0d", c, act_flags(), bus.odata,
                          exp_flags(), (q.size() != 0) ? q[0] : word_t'(0));
      end
`ifdef OUTBUF_STATS_EN
      tests++;
      if (nxfer !== m_xfer || nstall !== m_stall || nblock !== m_block) begin
        fails++; $display("FAIL random_stats[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", c,
                          nxfer, nstall, nblock, m_xfer, m_stall, m_block);
      end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, '0, 0, 0);
    test_reset();
    test_stream();
    test_fill();
    test_release();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
